// File: rtl/fp_pkg.sv
// Shared floating-point datapath definitions: default widths, exponent limit,
// normalizer FSM states and the result flag bundle.
package fp_pkg;

    localparam int FP_EW = 8;
    localparam int FP_MW = 24;

    localparam logic [FP_EW-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } norm_state_t;

    typedef struct packed {
        logic zero;
        logic ovf;
        logic unf;
    } fp_flags_t;

endpackage

// File: rtl/fp_normalizer.sv
// Sequential post-add normalizer: one mantissa shift per cycle, exponent tracked
// alongside, with zero/overflow/underflow detection and valid/ready on both sides.
module fp_normalizer
    import fp_pkg::*;
#(
    parameter int EW = FP_EW,
    parameter int MW = FP_MW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [EW-1:0] exp_in,
    input  logic [MW:0]   mant_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] exp_out,
    output logic [MW-1:0] mant_out,
    output logic          zero,
    output logic          ovf,
    output logic          unf
);

    localparam logic [EW-1:0] EXP_TOP = {EW{1'b1}};
    localparam logic [EW-1:0] EXP_ONE = EW'(1);

    norm_state_t   state_reg, state_next;
    logic [EW-1:0] exp_reg, exp_next;
    logic [MW:0]   mant_reg, mant_next;
    fp_flags_t     flags_reg, flags_next;
    logic [EW-1:0] exp_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            exp_reg   <= '0;
            mant_reg  <= '0;
            flags_reg <= '0;
        end else begin
            state_reg <= state_next;
            exp_reg   <= exp_next;
            mant_reg  <= mant_next;
            flags_reg <= flags_next;
        end
    end

    // exp_reg is never EXP_TOP when the increment is used, so it cannot wrap.
    assign exp_inc = exp_reg + EXP_ONE;

    always_comb begin
        state_next = state_reg;
        exp_next   = exp_reg;
        mant_next  = mant_reg;
        flags_next = flags_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    exp_next   = exp_in;
                    mant_next  = mant_in;
                    flags_next = '0;
                    state_next = ST_NORM;
                end
            end
            ST_NORM: begin
                state_next = ST_DONE;
                if (exp_reg == EXP_TOP) begin
                    mant_next      = '0;
                    flags_next.ovf = 1'b1;
                end else if (mant_reg == '0) begin
                    exp_next        = '0;
                    flags_next.zero = 1'b1;
                end else if (mant_reg[MW]) begin
                    mant_next = mant_reg >> 1;
                    exp_next  = exp_inc;
                    if (exp_inc == EXP_TOP) begin
                        mant_next      = '0;
                        flags_next.ovf = 1'b1;
                    end
                end else if (mant_reg[MW-1]) begin
                    state_next = ST_DONE;
                end else if (exp_reg <= EXP_ONE) begin
                    exp_next       = '0;
                    flags_next.unf = 1'b1;
                end else begin
                    mant_next  = {mant_reg[MW-1:0], 1'b0};
                    exp_next   = exp_reg - EXP_ONE;
                    state_next = ST_NORM;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == ST_IDLE);
        out_valid = (state_reg == ST_DONE);
        exp_out   = exp_reg;
        mant_out  = mant_reg[MW-1:0];
        zero      = flags_reg.zero;
        ovf       = flags_reg.ovf;
        unf       = flags_reg.unf;
    end

endmodule

// File: tb/tb_fp_normalizer.sv
// Randomized and directed checks of fp_normalizer against an arithmetic reference
// model of the normalization result and its latency.
module tb_fp_normalizer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  exp_in;
    logic [24:0] mant_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_out;
    logic [23:0] mant_out;
    logic        zero;
    logic        ovf;
    logic        unf;

    int total = 0;
    int bad   = 0;

    fp_normalizer #(.EW(8), .MW(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .exp_in    (exp_in),
        .mant_in   (mant_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp_out   (exp_out),
        .mant_out  (mant_out),
        .zero      (zero),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Result of normalization, computed from the leading-one position directly.
    // flags packed as {zero, ovf, unf}; k = number of left shifts performed.
    function automatic void ref_model(input int e, input logic [24:0] m,
                                      output int re, output logic [23:0] rm,
                                      output logic [2:0] rf, output int k);
        int p;
        int need;
        re = 0; rm = '0; rf = 3'b000; k = 0;
        if (e == 255) begin
            re = 255; rf = 3'b010;
        end else if (m == 25'd0) begin
            rf = 3'b100;
        end else if (m[24]) begin
            re = e + 1;
            rm = m[24:1];
            if (re == 255) begin
                rm = '0; rf = 3'b010;
            end
        end else begin
            p = -1;
            for (int i = 23; i >= 0; i--) if (p < 0 && m[i]) p = i;
            need = 23 - p;
            if (need == 0) begin
                re = e; rm = m[23:0];
            end else if (e >= 1 && need <= e - 1) begin
                re = e - need; rm = m[23:0] << need; k = need;
            end else begin
                k  = (e >= 1) ? e - 1 : 0;
                rm = m[23:0] << k;
                rf = 3'b001;
            end
        end
    endfunction

    // Called at #1 after a rising edge with the DUT idle.
    task automatic run_op(input int e, input logic [24:0] m, input int hold);
        int re, k, n;
        logic [23:0] rm;
        logic [2:0]  rf;
        ref_model(e, m, re, rm, rf, k);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        exp_in   = e[7:0];
        mant_in  = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, k + 1);
        chk("exp_out", {24'd0, exp_out}, re);
        chk("mant_out", {8'd0, mant_out}, {8'd0, rm});
        chk("flags", {29'd0, zero, ovf, unf}, {29'd0, rf});
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_exp", {24'd0, exp_out}, re);
            chk("hold_mant", {8'd0, mant_out}, {8'd0, rm});
            chk("hold_flags", {29'd0, zero, ovf, unf}, {29'd0, rf});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("handoff_valid", {31'd0, out_valid}, 32'd0);
        chk("handoff_ready", {31'd0, in_ready}, 32'd1);
        $display("op exp_in=%0d mant_in=%07h -> exp=%0d mant=%06h z/o/u=%b%b%b lat=%0d",
                 e, m, exp_out, mant_out, zero, ovf, unf, n);
    endtask

    initial begin
        int e;
        logic [24:0] m;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_in = '0; mant_in = '0;
        @(posedge clk); #1;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_outs", {exp_out, mant_out}, 32'd0);
        chk("rst_flags", {29'd0, zero, ovf, unf}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(130, 25'h0200000, 0);
        run_op(100, 25'h1800000, 0);
        run_op(254, 25'h1000000, 0);
        run_op(77,  25'h0000000, 0);
        run_op(3,   25'h0000100, 0);
        run_op(255, 25'h1234567, 0);
        run_op(0,   25'h0400000, 0);
        run_op(0,   25'h1000001, 0);
        run_op(1,   25'h0800001, 0);
        run_op(24,  25'h0000001, 0);
        run_op(40,  25'h0000001, 0);
        run_op(90,  25'h0123456, 5);

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0: e = $urandom_range(0, 4);
                1: e = $urandom_range(250, 255);
                default: e = $urandom_range(0, 255);
            endcase
            m = 25'($urandom) >> $urandom_range(0, 25);
            run_op(e, m, $urandom_range(0, 2));
        end

        // Reset in the middle of a 10-shift normalization.
        in_valid = 1'b1; exp_in = 8'd50; mant_in = 25'h0002000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_outs", {exp_out, mant_out}, 32'd0);
        chk("midrst_flags", {29'd0, zero, ovf, unf}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            chk("postrst_valid", {31'd0, out_valid}, 32'd0);
        end
        run_op(130, 25'h0200000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
